// File: rtl/hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_secded_pipe
//  Description : Two-stage pipelined SECDED Hamming decoder for 2^R-bit
//                codewords (Hamming positions 1..2^R-1 plus an overall
//                even-parity bit in the MSB). It has a valid/ready stream
//                interface with backpressure, per-word correction flags and
//                saturating error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_secded_pipe #(
   parameter  int R      = 4,
   parameter  int CNT_W  = 16,
   localparam int CODE_W = 1 << R,
   localparam int DATA_W = (1 << R) - R - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_corr,
   output logic              out_uncorr,
   output logic [R-1:0]      out_pos,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt_corr,
   output logic [CNT_W-1:0]  cnt_uncorr
);

   // Stage 1 state: the received word plus its syndrome and overall parity
   logic              r_s1_valid;
   logic [CODE_W-1:0] r_s1_code;
   logic [R-1:0]      r_s1_syn;
   logic              r_s1_par;

   // Stage 2 state: the decoded result presented to the consumer
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_corr;
   logic              r_out_uncorr;
   logic [R-1:0]      r_out_pos;

   logic [CNT_W-1:0]  r_cnt_corr;
   logic [CNT_W-1:0]  r_cnt_uncorr;

   logic              w_en;
   logic              w_xfer;
   logic [R-1:0]      w_syn;
   logic              w_par;
   logic [CODE_W-1:0] w_fixed;
   logic [DATA_W-1:0] w_data;
   logic              w_uncorr;

   // The whole pipe advances only when the output slot is free or draining
   assign w_en     = ~r_out_valid | out_ready;
   assign in_ready = w_en;
   assign w_xfer   = r_out_valid & out_ready;

   // Syndrome bit k collects every Hamming position whose index has bit k set
   always_comb begin
      w_syn = '0;
      for (int p = 1; p < CODE_W; p++) begin
         for (int k = 0; k < R; k++) begin
            if (((p >> k) & 1) != 0) begin
               w_syn[k] = w_syn[k] ^ in_code[CODE_W-1-p];
            end
         end
      end
   end

   assign w_par = ^in_code;

   // Flip the position named by the syndrome only when overall parity says a
   // single (odd) error occurred; a zero syndrome then means the parity bit
   // itself was hit and the data needs no repair
   always_comb begin
      w_fixed = r_s1_code;
      for (int p = 1; p < CODE_W; p++) begin
         if (r_s1_par && (int'(r_s1_syn) == p)) begin
            w_fixed[CODE_W-1-p] = ~r_s1_code[CODE_W-1-p];
         end
      end
   end

   // Gather the non-power-of-two positions, lowest position into the MSB
   always_comb begin
      int d;
      d      = DATA_W - 1;
      w_data = '0;
      for (int p = 1; p < CODE_W; p++) begin
         if ((p & (p - 1)) != 0) begin
            w_data[d] = w_fixed[CODE_W-1-p];
            d         = d - 1;
         end
      end
   end

   // Even overall parity with a non-zero syndrome indicates a double error
   assign w_uncorr = ~r_s1_par & (|r_s1_syn);

   // Stage 1 register: capture the accepted word and its checks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_code  <= '0;
         r_s1_syn   <= '0;
         r_s1_par   <= 1'b0;
      end else if (w_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_code <= in_code;
            r_s1_syn  <= w_syn;
            r_s1_par  <= w_par;
         end
      end
   end

   // Stage 2 register: corrected data and flags, held steady while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_corr   <= 1'b0;
         r_out_uncorr <= 1'b0;
         r_out_pos    <= '0;
      end else if (w_en) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_data   <= w_data;
            r_out_corr   <= r_s1_par;
            r_out_uncorr <= w_uncorr;
            r_out_pos    <= r_s1_syn;
         end
      end
   end

   // Saturating error counters, bumped on output transfers; clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_corr   <= '0;
         r_cnt_uncorr <= '0;
      end else if (cnt_clr) begin
         r_cnt_corr   <= '0;
         r_cnt_uncorr <= '0;
      end else if (w_xfer) begin
         if (r_out_corr && (r_cnt_corr != '1)) begin
            r_cnt_corr <= r_cnt_corr + 1'b1;
         end
         if (r_out_uncorr && (r_cnt_uncorr != '1)) begin
            r_cnt_uncorr <= r_cnt_uncorr + 1'b1;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_corr   = r_out_corr;
   assign out_uncorr = r_out_uncorr;
   assign out_pos    = r_out_pos;
   assign cnt_corr   = r_cnt_corr;
   assign cnt_uncorr = r_cnt_uncorr;

endmodule
`default_nettype wire
